// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one divider between two requesters, with a watchdog and a tagged response.
// Grant is combinational in IDLE; start follows one cycle later; response one cycle after the terminating divider event.
module div_arbiter #(
    parameter int N       = 5,
    parameter int TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [2*N-1:0]   dvd0_i,
    input  logic [2*N-1:0]   dvd1_i,
    input  logic [N-1:0]     dvs0_i,
    input  logic [N-1:0]     dvs1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             div_start_o,
    output logic [2*N-1:0]   div_dvd_o,
    output logic [N-1:0]     div_dvs_o,
    output logic             div_clr_o,
    input  logic             div_doneq_i,
    input  logic             div_donew_i,
    input  logic             div_dbz_i,
    input  logic             div_ov_i,
    input  logic [N-1:0]     div_result_i,
    output logic             busy_o,
    output logic             rsp_valid_o,
    output logic             rsp_id_o,
    output logic [N-1:0]     rsp_quo_o,
    output logic [N-1:0]     rsp_rem_o,
    output logic             rsp_dbz_o,
    output logic             rsp_ov_o,
    output logic             rsp_err_o
);

    // Holds TIMEOUT+1, reached when a completion wins the expiry cycle and the wait continues.
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAITQ,
        S_WAITR,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            expire;
    logic [N-1:0]    quo_q, quo_d;
    logic            prio_q;
    logic            owner_q;
    logic [2*N-1:0]  dvd_q;
    logic [N-1:0]    dvs_q;

    logic            rsp_id_q;
    logic [N-1:0]    rsp_quo_q, rsp_rem_q;
    logic            rsp_dbz_q, rsp_ov_q, rsp_err_q;

    logic            gnt_any, gnt_sel;
    logic            fin, fin_dbz, fin_ov, fin_err;
    logic [N-1:0]    fin_quo, fin_rem;

    // prio_q names the port that wins when both request.
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = 1'b0;
        if (state_q == S_IDLE) begin
            if (req0_i && req1_i) begin
                gnt_any = 1'b1;
                gnt_sel = prio_q;
            end else if (req0_i) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b0;
            end else if (req1_i) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b1;
            end
        end
    end

    assign cnt_inc = cnt_q + CW'(1);
    assign expire  = (cnt_inc >= TMO);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        fin     = 1'b0;
        fin_dbz = 1'b0;
        fin_ov  = 1'b0;
        fin_err = 1'b0;
        fin_quo = '0;
        fin_rem = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAITQ;
            end
            S_WAITQ: begin
                cnt_d = cnt_inc;
                if (div_dbz_i) begin
                    fin     = 1'b1;
                    fin_dbz = 1'b1;
                end else if (div_ov_i) begin
                    fin    = 1'b1;
                    fin_ov = 1'b1;
                end else if (div_doneq_i) begin
                    quo_d   = div_result_i;
                    state_d = S_WAITR;
                end else if (expire) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            S_WAITR: begin
                cnt_d = cnt_inc;
                if (div_donew_i) begin
                    fin     = 1'b1;
                    fin_quo = quo_q;
                    fin_rem = div_result_i;
                end else if (expire) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (fin) state_d = S_RESP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rsp_id_q  <= 1'b0;
            rsp_quo_q <= '0;
            rsp_rem_q <= '0;
            rsp_dbz_q <= 1'b0;
            rsp_ov_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            if (gnt_any) begin
                dvd_q   <= gnt_sel ? dvd1_i : dvd0_i;
                dvs_q   <= gnt_sel ? dvs1_i : dvs0_i;
                owner_q <= gnt_sel;
                prio_q  <= ~gnt_sel;
            end
            // Response fields load only at termination so they hold until the next response.
            if (fin) begin
                rsp_id_q  <= owner_q;
                rsp_quo_q <= fin_quo;
                rsp_rem_q <= fin_rem;
                rsp_dbz_q <= fin_dbz;
                rsp_ov_q  <= fin_ov;
                rsp_err_q <= fin_err;
            end
        end
    end

    assign gnt0_o      = gnt_any && !gnt_sel;
    assign gnt1_o      = gnt_any && gnt_sel;
    assign div_start_o = (state_q == S_ISSUE);
    assign div_dvd_o   = dvd_q;
    assign div_dvs_o   = dvs_q;
    assign busy_o      = (state_q != S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign div_clr_o   = (state_q == S_RESP) && rsp_err_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_quo_o   = rsp_quo_q;
    assign rsp_rem_o   = rsp_rem_q;
    assign rsp_dbz_o   = rsp_dbz_q;
    assign rsp_ov_o    = rsp_ov_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
